// File: rtl/axis_dense_stream_buffer.sv
// AXI-Stream input/output buffering for the dense layer datapath.
// Optional AXIS_TLAST_CHECK_EN: validate s_axis_tlast and flag frame errors.
module axis_dense_stream_buffer #(
    parameter int DATA_SIZE     = 32,
    parameter int IN_COUNT      = 1600,
    parameter int OUT_COUNT     = 10,
    parameter int IN_ADR_WIDTH  = 11,
    parameter int OUT_ADR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_SIZE-1:0]     s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_SIZE-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic [IN_ADR_WIDTH-1:0]  bufferIn_adr,
    output logic [DATA_SIZE-1:0]     bufferIn_data,
    input  logic [OUT_ADR_WIDTH-1:0] bufferOut_adr,
    input  logic [DATA_SIZE-1:0]     bufferOut_data,
    input  logic                     bufferOut_we,
    input  logic                     putData,
    output logic                     gotData,
    output logic                     frameErr
);

    localparam logic [1:0] RECV    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam logic [IN_ADR_WIDTH-1:0]  IN_LAST  = IN_ADR_WIDTH'(IN_COUNT - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] OUT_LAST = OUT_ADR_WIDTH'(OUT_COUNT - 1);
    localparam logic [OUT_ADR_WIDTH:0]   OUT_LIM  = (OUT_ADR_WIDTH + 1)'(OUT_COUNT);

    logic [1:0]               state;
    logic [IN_ADR_WIDTH-1:0]  wr_cnt;
    logic [OUT_ADR_WIDTH-1:0] rd_cnt;
    logic [OUT_ADR_WIDTH-1:0] rd_nxt;

    logic [DATA_SIZE-1:0] in_buf  [IN_COUNT];
    logic [DATA_SIZE-1:0] out_buf [OUT_COUNT];

    logic in_beat;
    logic in_last;
    logic frame_end;
    logic out_we;

    // Gated by rst so the port reads 0 throughout reset even though state is RECV.
    assign s_axis_tready = rst & (state == RECV);
    assign in_beat       = s_axis_tvalid & s_axis_tready;
    assign in_last       = (wr_cnt == IN_LAST);
    assign rd_nxt        = rd_cnt + OUT_ADR_WIDTH'(1);
    assign out_we        = (state == COMPUTE) & bufferOut_we
                         & ({1'b0, bufferOut_adr} < OUT_LIM);

`ifdef AXIS_TLAST_CHECK_EN
    logic tlast_bad;

    assign tlast_bad = in_beat & (s_axis_tlast != in_last);
    assign frame_end = in_beat & (in_last | s_axis_tlast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frameErr <= 1'b0;
        end else if (tlast_bad) begin
            frameErr <= 1'b1;
        end
    end
`else
    logic tlast_unused;

    assign tlast_unused = s_axis_tlast;
    assign frame_end    = in_beat & in_last;
    assign frameErr     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (in_beat) begin
            in_buf[wr_cnt] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (out_we) begin
            out_buf[bufferOut_adr] <= bufferOut_data;
        end
    end

    assign bufferIn_data = in_buf[bufferIn_adr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RECV;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            gotData       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            gotData <= 1'b0;
            case (state)
                RECV: begin
                    if (frame_end) begin
                        wr_cnt  <= '0;
                        state   <= COMPUTE;
                        gotData <= 1'b1;
                    end else if (in_beat) begin
                        wr_cnt <= wr_cnt + IN_ADR_WIDTH'(1);
                    end
                end
                COMPUTE: begin
                    if (putData) begin
                        rd_cnt <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    // First SEND cycle primes the output register from word 0.
                    if (!m_axis_tvalid) begin
                        m_axis_tdata  <= out_buf[rd_cnt];
                        m_axis_tlast  <= (rd_cnt == OUT_LAST);
                        m_axis_tvalid <= 1'b1;
                    end else if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            rd_cnt        <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state         <= RECV;
                        end else begin
                            rd_cnt       <= rd_nxt;
                            m_axis_tdata <= out_buf[rd_nxt];
                            m_axis_tlast <= (rd_nxt == OUT_LAST);
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_dense_stream_buffer.sv
// Scoreboard bench for axis_dense_stream_buffer.
// Honours AXIS_TLAST_CHECK_EN for the early-tlast scenario.
module tb_axis_dense_stream_buffer;

    localparam int DW  = 32;
    localparam int IC  = 1600;
    localparam int OC  = 10;
    localparam int IAW = 11;
    localparam int OAW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b1;
    logic [IAW-1:0] bufferIn_adr = '0;
    logic [DW-1:0]  bufferIn_data;
    logic [OAW-1:0] bufferOut_adr = '0;
    logic [DW-1:0]  bufferOut_data = '0;
    logic           bufferOut_we = 1'b0;
    logic           putData = 1'b0;
    logic           gotData;
    logic           frameErr;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   fails   = 0;
    int   got_cnt = 0;

    axis_dense_stream_buffer #(
        .DATA_SIZE(DW), .IN_COUNT(IC), .OUT_COUNT(OC),
        .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .bufferIn_adr(bufferIn_adr), .bufferIn_data(bufferIn_data),
        .bufferOut_adr(bufferOut_adr), .bufferOut_data(bufferOut_data),
        .bufferOut_we(bufferOut_we), .putData(putData),
        .gotData(gotData), .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    // Output monitor: every presented word must match the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (gotData) got_cnt++;
        if (m_axis_tvalid) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL m_axis_extra: tvalid=1 data=%h, no word expected", m_axis_tdata);
            end else begin
                checks++;
                if (m_axis_tdata !== sb[0].data || m_axis_tlast !== sb[0].last) begin
                    fails++;
                    $display("FAIL m_axis_word: got %h/last=%b, expected %h/last=%b",
                             m_axis_tdata, m_axis_tlast, sb[0].data, sb[0].last);
                end
                if (m_axis_tready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic feed(input int n, input int base, input int tlast_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(base + i);
            s_axis_tlast  = (i == tlast_at);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic write_word(input int a, input int d, input logic put);
        @(negedge clk);
        bufferOut_we   = 1'b1;
        bufferOut_adr  = OAW'(a);
        bufferOut_data = DW'(d);
        putData        = put;
        @(negedge clk);
        bufferOut_we = 1'b0;
        putData      = 1'b0;
    endtask

    task automatic start_send;
        @(negedge clk);
        putData = 1'b1;
        @(negedge clk);
        putData = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, gotData, frameErr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, gotData, frameErr});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_tready: got %b, expected 1", s_axis_tready);
        end
    endtask

    task automatic test_input_frame(input int base);
        int g0;
        g0 = got_cnt;
        feed(IC, base, IC - 1);
        checks++;
        if (gotData !== 1'b1) begin
            fails++;
            $display("FAIL frame_gotdata: got %b, expected 1", gotData);
        end
        checks++;
        if (s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL frame_tready_compute: got %b, expected 0", s_axis_tready);
        end
        @(negedge clk);
        checks++;
        if (gotData !== 1'b0) begin
            fails++;
            $display("FAIL frame_gotdata_width: got %b, expected 0", gotData);
        end
        @(negedge clk);
        #3;
        checks++;
        if (got_cnt - g0 !== 1) begin
            fails++;
            $display("FAIL frame_gotdata_count: got %0d, expected 1", got_cnt - g0);
        end
        bufferIn_adr = IAW'(1234);
        #1;
        checks++;
        if (bufferIn_data !== DW'(base + 1234)) begin
            fails++;
            $display("FAIL frame_read_1234: got %h, expected %h", bufferIn_data, DW'(base + 1234));
        end
        bufferIn_adr = '0;
        #1;
        checks++;
        if (bufferIn_data !== DW'(base)) begin
            fails++;
            $display("FAIL frame_read_0: got %h, expected %h", bufferIn_data, DW'(base));
        end
        bufferIn_adr = IAW'(IC - 1);
        #1;
        checks++;
        if (bufferIn_data !== DW'(base + IC - 1)) begin
            fails++;
            $display("FAIL frame_read_last: got %h, expected %h", bufferIn_data, DW'(base + IC - 1));
        end
    endtask

    task automatic test_compute_send;
        m_axis_tready = 1'b1;
        for (int k = 0; k < OC; k++) begin
            write_word(k, 100 + k, 1'b0);
            sb.push_back('{data: DW'(100 + k), last: (k == OC - 1)});
        end
        start_send;
        for (int c = 0; c < 100 && (sb.size() != 0 || m_axis_tvalid); c++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL send_drain: %0d words left, expected 0", sb.size());
        end
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL send_return_recv: tready=%b tvalid=%b, expected 1/0",
                     s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_stall;
        logic [3:0] pat;
        int stalls;
        pat = 4'b1001;
        stalls = 0;
        test_input_frame(7000);
        for (int k = 0; k < OC; k++) begin
            write_word(k, 200 + k, 1'b0);
            sb.push_back('{data: DW'(200 + k), last: (k == OC - 1)});
        end
        start_send;
        for (int c = 0; c < 200 && (sb.size() != 0 || m_axis_tvalid); c++) begin
            @(negedge clk);
            m_axis_tready = pat[c % 4];
            if (m_axis_tvalid && !m_axis_tready) stalls++;
        end
        m_axis_tready = 1'b1;
        checks++;
        if (sb.size() != 0 || stalls == 0) begin
            fails++;
            $display("FAIL stall_drain: left=%0d stalls=%0d, expected 0 left and stalls>0",
                     sb.size(), stalls);
        end
        @(negedge clk);
    endtask

    task automatic test_same_cycle;
        test_input_frame(11000);
        for (int k = 0; k < OC - 1; k++) begin
            write_word(k, 300 + k, 1'b0);
            sb.push_back('{data: DW'(300 + k), last: 1'b0});
        end
        write_word(OC - 1, 'hDEAD, 1'b1);
        sb.push_back('{data: DW'('hDEAD), last: 1'b1});
        for (int c = 0; c < 100 && (sb.size() != 0 || m_axis_tvalid); c++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL same_cycle_drain: %0d words left, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        @(negedge clk);
        putData        = 1'b1;
        bufferOut_we   = 1'b1;
        bufferOut_adr  = '0;
        bufferOut_data = DW'('hFFFF);
        @(negedge clk);
        putData      = 1'b0;
        bufferOut_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
                fails++;
                $display("FAIL ignored_putdata: tvalid=%b tready=%b, expected 0/1",
                         m_axis_tvalid, s_axis_tready);
            end
        end
    endtask

    task automatic test_drop;
        test_input_frame(13000);
        sb.push_back('{data: DW'(300), last: 1'b0});
        for (int k = 1; k < OC; k++) begin
            write_word(k, 400 + k, 1'b0);
            sb.push_back('{data: DW'(400 + k), last: (k == OC - 1)});
        end
        write_word(12, 'hBAD, 1'b0);
        write_word(10, 'hBAD, 1'b0);
        write_word(15, 'hBAD, 1'b0);
        start_send;
        for (int c = 0; c < 100 && (sb.size() != 0 || m_axis_tvalid); c++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drop_drain: %0d words left, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int g0;
        g0 = got_cnt;
        feed(800, 20000, -1);
        rst = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, gotData, frameErr} !== 5'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got %b, expected 00000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, gotData, frameErr});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #3;
        checks++;
        if (got_cnt != g0) begin
            fails++;
            $display("FAIL midreset_gotdata: got %0d pulses, expected 0", got_cnt - g0);
        end
        test_input_frame(5000);
    endtask

    task automatic test_tlast;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        feed(501, 9000, 500);
`ifdef AXIS_TLAST_CHECK_EN
        checks++;
        if (gotData !== 1'b1 || frameErr !== 1'b1 || s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL tlast_early: got=%b err=%b tready=%b, expected 1/1/0",
                     gotData, frameErr, s_axis_tready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (frameErr !== 1'b1 || s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL tlast_sticky: err=%b tready=%b, expected 1/0", frameErr, s_axis_tready);
        end
        bufferIn_adr = IAW'(501);
        #1;
        checks++;
        if (bufferIn_data !== DW'(5501)) begin
            fails++;
            $display("FAIL tlast_stale: got %h, expected %h", bufferIn_data, DW'(5501));
        end
`else
        checks++;
        if (gotData !== 1'b0 || frameErr !== 1'b0 || s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL tlast_ignored: got=%b err=%b tready=%b, expected 0/0/1",
                     gotData, frameErr, s_axis_tready);
        end
        feed(IC - 501, 9501, -1);
        checks++;
        if (gotData !== 1'b1 || frameErr !== 1'b0) begin
            fails++;
            $display("FAIL tlast_beat_count: got=%b err=%b, expected 1/0", gotData, frameErr);
        end
`endif
        bufferIn_adr = IAW'(500);
        #1;
        checks++;
        if (bufferIn_data !== DW'(9500)) begin
            fails++;
            $display("FAIL tlast_word500: got %h, expected %h", bufferIn_data, DW'(9500));
        end
    endtask

    initial begin
        test_reset;
        test_input_frame(0);
        test_compute_send;
        test_stall;
        test_same_cycle;
        test_ignored;
        test_drop;
        test_reset_mid_frame;
        test_tlast;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
